dt_engine_csr_bank: RTL

Parametrised soft-register bank for the DT engine, the successor to the fixed-layout engine CSR. It decodes SoftRegReq reads and writes inside a relocatable address window and drives mode flags, a saturating batch size and an N-entry FPGA device list. It also runs a start/run/done control FSM with a programmable start delay, locks configuration while the engine runs, and exposes cycle and error counters for read-back. It sits between the shell soft-register port and the DT engine top.

---
 rtl/dt_engine_csr_bank_pkg.sv | 38 +++
 rtl/dt_engine_csr_bank_start_fsm.sv | 76 +++++++
 rtl/dt_engine_csr_bank.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dt_engine_csr_bank_pkg.sv
// rtl/dt_engine_csr_bank_pkg.sv - shared types, offsets, FSM states and helpers for the DT engine CSR bank
package DTEngine_Types;

    localparam int ADDR_W      = 32;
    localparam int WINDOW_SIZE = 17;

    typedef struct packed {
        logic              valid;
        logic              isWrite;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    typedef enum logic [4:0] {
        CTRL   = 5'd0,
        MODE   = 5'd1,
        BATCH  = 5'd2,
        DEV0   = 5'd3,
        STATUS = 5'd16
    } CsrOffset;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } CsrState;

    // Minus-one fields clamp at zero instead of wrapping to all-ones.
    function automatic logic [31:0] sat_dec(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x - 32'd1;
    endfunction

endpackage

// File: rtl/dt_engine_csr_bank_start_fsm.sv
// rtl/dt_engine_csr_bank_start_fsm.sv - start/run/done control FSM with programmable start delay and run-cycle counter
module dt_csr_start_fsm
    import DTEngine_Types::*;
#(
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_req,
    input  logic        abort_req,
    input  logic        core_done,
    output CsrState     state,
    output logic        busy,
    output logic        start_core,
    output logic [31:0] run_cycles
);

    CsrState    state_q, state_d;
    logic [3:0] dly_q, dly_d;
    logic       start_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dly_q      <= 4'd0;
            start_core <= 1'b0;
            run_cycles <= 32'd0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            start_core <= start_d;
            if (state_q == IDLE && state_d == DELAY) begin
                run_cycles <= 32'd0;
            end else if (state_q == RUN) begin
                run_cycles <= run_cycles + 32'd1;
            end
        end
    end

    // Abort outranks both start and core_done; done outside RUN is ignored.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_req && !abort_req) begin
                    state_d = DELAY;
                    dly_d   = 4'(START_DELAY - 1);
                end
            end
            DELAY: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (dly_q == 4'd0) begin
                    state_d = RUN;
                    start_d = 1'b1;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            RUN: begin
                if (abort_req || core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        state = state_q;
        busy  = (state_q != IDLE);
    end

endmodule

// File: rtl/dt_engine_csr_bank.sv
// rtl/dt_engine_csr_bank.sv - DT engine soft-register bank; config read-back enabled by DT_CSR_READBACK_EN
module dt_engine_csr_bank
    import DTEngine_Types::*;
#(
    parameter int BASE_ADDR   = 200,
    parameter int NUM_DEVS    = 20,
    parameter int DEV_ADDR_W  = 5,
    parameter int START_DELAY = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  SoftRegReq                      softreg_req,
    output SoftRegResp                     softreg_resp,
    input  logic                           core_done,
    output logic                           start_core,
    output logic                           busy,
    output logic [7:0]                     mode_flags,
    output logic [31:0]                    batch_cls_minus_one,
    output logic [5:0]                     num_devs_minus_one,
    output logic [NUM_DEVS*DEV_ADDR_W-1:0] devices_list
);

    localparam int DW       = (NUM_DEVS + 7) / 8;
    localparam int DEV_LAST = 3 + DW - 1;

    logic [ADDR_W-1:0]     rel_addr;
    logic [4:0]            off;
    logic                  in_win, is_wr, is_rd, is_cfg, cfg_wr;
    logic                  start_req, abort_req, reject;
    logic [7:0]            mode_q;
    logic [5:0]            ndev_q;
    logic [31:0]           batch_q;
    logic [DEV_ADDR_W-1:0] devs_q [NUM_DEVS];
    logic [15:0]           rejected_cnt;
    logic [31:0]           run_cycles;
    CsrState               fsm_state;
    logic [63:0]           rd_data;
    logic                  unused_data;

    assign rel_addr  = softreg_req.addr - ADDR_W'(BASE_ADDR);
    assign in_win    = (softreg_req.addr >= ADDR_W'(BASE_ADDR)) && (rel_addr < ADDR_W'(WINDOW_SIZE));
    assign off       = rel_addr[4:0];
    assign is_wr     = softreg_req.valid && softreg_req.isWrite && in_win;
    assign is_rd     = softreg_req.valid && !softreg_req.isWrite;
    assign is_cfg    = (off >= MODE) && (off <= 5'(DEV_LAST));
    assign cfg_wr    = is_wr && is_cfg && !busy;
    assign start_req = is_wr && (off == CTRL) && softreg_req.data[0];
    assign abort_req = is_wr && (off == CTRL) && softreg_req.data[1];
    // Config writes and bare starts while running are refused and counted.
    assign reject    = busy && is_wr && (is_cfg || (start_req && !abort_req));
    assign unused_data = ^softreg_req.data;

    dt_csr_start_fsm #(
        .START_DELAY (START_DELAY)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_req  (start_req),
        .abort_req  (abort_req),
        .core_done  (core_done),
        .state      (fsm_state),
        .busy       (busy),
        .start_core (start_core),
        .run_cycles (run_cycles)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q       <= 8'd0;
            ndev_q       <= 6'd0;
            batch_q      <= 32'd0;
            rejected_cnt <= 16'd0;
            for (int i = 0; i < NUM_DEVS; i++) begin
                devs_q[i] <= '0;
            end
        end else begin
            if (cfg_wr && off == MODE) begin
                mode_q <= softreg_req.data[7:0];
                ndev_q <= softreg_req.data[37:32];
            end
            if (cfg_wr && off == BATCH) begin
                batch_q <= softreg_req.data[31:0];
            end
            for (int i = 0; i < NUM_DEVS; i++) begin
                if (cfg_wr && off == 5'(3 + i / 8)) begin
                    devs_q[i] <= softreg_req.data[8*(i%8) +: DEV_ADDR_W];
                end
            end
            if (reject && rejected_cnt != 16'hFFFF) begin
                rejected_cnt <= rejected_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        rd_data = '1;
        if (in_win) begin
            if (off == STATUS) begin
                rd_data = {14'd0, fsm_state, rejected_cnt, run_cycles};
            end
`ifdef DT_CSR_READBACK_EN
            else if (off == MODE) begin
                rd_data = {26'd0, ndev_q, 24'd0, mode_q};
            end else if (off == BATCH) begin
                rd_data = {32'd0, batch_q};
            end else if (off >= DEV0 && off <= 5'(DEV_LAST)) begin
                rd_data = '0;
                for (int i = 0; i < NUM_DEVS; i++) begin
                    if (off == 5'(3 + i / 8)) begin
                        rd_data[8*(i%8) +: DEV_ADDR_W] = devs_q[i];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            softreg_resp <= '0;
        end else begin
            softreg_resp.valid <= is_rd;
            softreg_resp.data  <= is_rd ? rd_data : 64'd0;
        end
    end

    assign mode_flags          = mode_q;
    assign batch_cls_minus_one = sat_dec(batch_q);
    assign num_devs_minus_one  = 6'(sat_dec(32'(ndev_q)));

    for (genvar g = 0; g < NUM_DEVS; g++) begin : g_dev
        assign devices_list[g*DEV_ADDR_W +: DEV_ADDR_W] = devs_q[g];
    end

endmodule
